codpri_arb: RTL and testbench

- Parametrised, registered successor to the team's combinational 16-to-4 priority encoder.
- Latches sticky request bits and applies a per-bit mask.
- Selects one winner by fixed priority or rotating (round-robin) priority.
- Presents the winner's index with a valid/ack handshake. Used as an interrupt/request controller in front of a sequential consumer.

---
 rtl/codpri_arb.sv | 108 ++++++++++
 tb/tb_codpri_arb.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codpri_arb.sv
// Registered priority arbiter with sticky requests and a per-line mask.
// Fixed or rotating priority; the winner is held under a valid/ack handshake.
module codpri_arb #(
  parameter int N = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         mask,
  input  logic                 mode,
  input  logic                 ack,
  output logic [$clog2(N)-1:0] y,
  output logic                 valid,
  output logic [N-1:0]         pending
);

  localparam int W = $clog2(N);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_pending;
  logic [N-1:0]   w_cand;
  logic [N-1:0]   w_clr;
  logic [W-1:0]   r_y;
  logic [W-1:0]   r_ptr;
  logic [W-1:0]   w_fix;
  logic [W-1:0]   w_rot;
  logic [W-1:0]   w_win;
  logic           w_any;
  logic           w_fire;
  logic           w_load;

  assign w_cand  = r_pending & ~mask;
  assign w_any   = |w_cand;
  assign w_fire  = (r_state == GRANT) & ack;
  assign w_load  = (r_state == IDLE) & w_any;
  assign w_clr   = w_fire ? ({{(N-1){1'b0}}, 1'b1} << r_y) : '0;
  assign w_win   = mode ? w_rot : w_fix;

  assign y       = r_y;
  assign valid   = (r_state == GRANT);
  assign pending = r_pending;

  // Fixed priority: highest set candidate index wins.
  always_comb begin
    w_fix = '0;
    for (int i = 0; i < N; i++) begin
      if (w_cand[i]) w_fix = W'(i);
    end
  end

  // Rotating priority: first candidate found scanning down from ptr, wrapping.
  always_comb begin : rot_search
    logic         found;
    logic [W:0]   idx;
    w_rot = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, r_ptr} + (W+1)'(N) - (W+1)'(i);
      if (idx >= (W+1)'(N)) idx = idx - (W+1)'(N);
      if (!found && w_cand[idx[W-1:0]]) begin
        w_rot = idx[W-1:0];
        found = 1'b1;
      end
    end
  end

  // Next-state logic for the grant handshake.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_state_nxt = GRANT;
      GRANT:   if (ack)   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Sticky requests; a new request beats the clear of an accepted grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_pending <= '0;
    else       r_pending <= (r_pending & ~w_clr) | req;
  end

  // Grant index captured when leaving IDLE, held otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       r_y <= '0;
    else if (w_load) r_y <= w_win;
  end

  // Served line drops to lowest rotating priority on acceptance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       r_ptr <= W'(N-1);
    else if (w_fire) r_ptr <= (r_y == '0) ? W'(N-1) : r_y - W'(1);
  end

endmodule

// File: tb/tb_codpri_arb.sv
// Bench for codpri_arb: directed scenarios plus random traffic,
// all checked against a cycle reference model of the arbitration rules.
module tb_codpri_arb;

  localparam int N = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N-1:0]  mask;
  logic          mode;
  logic          ack;
  logic [3:0]    y;
  logic          valid;
  logic [N-1:0]  pending;

  int checks = 0;
  int fails  = 0;

  logic [N-1:0]  m_pend;
  bit            m_valid;
  int            m_y;
  int            m_ptr;

  int            got[$];

  always #5 clock = ~clock;

  codpri_arb #(.N(N)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .mask    (mask),
    .mode    (mode),
    .ack     (ack),
    .y       (y),
    .valid   (valid),
    .pending (pending)
  );

  function automatic int fixed_ref(logic [N-1:0] c);
    for (int i = N - 1; i >= 0; i--)
      if (c[i]) return i;
    return -1;
  endfunction

  // Winner is the set line at the smallest downward distance from ptr.
  function automatic int rot_ref(logic [N-1:0] c, int p);
    int best;
    int bd;
    best = -1;
    bd   = N + 1;
    for (int i = 0; i < N; i++) begin
      if (c[i] && ((p - i + N) % N) < bd) begin
        bd   = (p - i + N) % N;
        best = i;
      end
    end
    return best;
  endfunction

  function automatic void model_reset();
    m_pend  = '0;
    m_valid = 1'b0;
    m_y     = 0;
    m_ptr   = N - 1;
  endfunction

  function automatic void model_step();
    logic [N-1:0] cand;
    logic [N-1:0] clr;
    logic [N-1:0] npend;
    cand  = m_pend & ~mask;
    clr   = (m_valid && ack) ? (N'(1) << m_y) : '0;
    npend = (m_pend & ~clr) | req;
    if (m_valid) begin
      if (ack) begin
        m_valid = 1'b0;
        m_ptr   = (m_y == 0) ? N - 1 : m_y - 1;
      end
    end else if (cand != '0) begin
      m_y     = mode ? rot_ref(cand, m_ptr) : fixed_ref(cand);
      m_valid = 1'b1;
    end
    m_pend = npend;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".y"}, int'(y), m_y);
    chk({tag, ".valid"}, int'(valid), int'(m_valid));
    chk({tag, ".pending"}, int'(pending), int'(m_pend));
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clock);
    #1;
    chk_model(tag);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk_model("rst");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    mask  = '0;
    mode  = 1'b0;
    ack   = 1'b0;
    model_reset();
    #12;
    chk("reset.y", int'(y), 0);
    chk("reset.valid", int'(valid), 0);
    chk("reset.pending", int'(pending), 0);
    reset = 1'b0;

    // Fixed basic
    req = 16'h0030;
    step("fx1");
    chk("fx.pend", int'(pending), 16'h0030);
    chk("fx.v0", int'(valid), 0);
    req = '0;
    step("fx2");
    chk("fx.y5", int'(y), 5);
    chk("fx.v5", int'(valid), 1);
    ack = 1'b1;
    step("fx3");
    chk("fx.gap", int'(valid), 0);
    ack = 1'b0;
    step("fx4");
    chk("fx.y4", int'(y), 4);
    chk("fx.v4", int'(valid), 1);
    ack = 1'b1;
    step("fx5");
    chk("fx.end_v", int'(valid), 0);
    chk("fx.end_p", int'(pending), 0);
    ack = 1'b0;

    // Mask
    req = 16'h8001;
    step("mk1");
    req  = '0;
    mask = 16'h8000;
    step("mk2");
    chk("mk.y0", int'(y), 0);
    ack = 1'b1;
    step("mk3");
    ack  = 1'b0;
    mask = '0;
    step("mk4");
    chk("mk.y15", int'(y), 15);
    chk("mk.v15", int'(valid), 1);
    ack = 1'b1;
    step("mk5");
    ack  = 1'b0;
    mask = 16'hFFFF;
    req  = 16'h0104;
    step("mk6");
    req = '0;
    for (int i = 0; i < 3; i++) begin
      step("mkall");
      chk("mk.all_v", int'(valid), 0);
    end
    chk("mk.all_p", int'(pending), 16'h0104);
    mask = '0;
    step("mk7");
    chk("mk.unmask_y", int'(y), 8);
    ack = 1'b1;
    step("mk8");
    ack = 1'b0;
    step("mk9");
    chk("mk.y2", int'(y), 2);
    ack = 1'b1;
    step("mk10");
    ack = 1'b0;

    // Rotating
    @(negedge clock);
    pulse_reset();
    mode = 1'b1;
    got.delete();
    for (int c = 0; c < 14 && got.size() < 5; c++) begin
      req = 16'h8101;
      ack = m_valid;
      if (ack) got.push_back(int'(y));
      step("rot");
    end
    req = '0;
    ack = 1'b0;
    chk("rot.n", got.size(), 5);
    chk("rot.g0", got[0], 15);
    chk("rot.g1", got[1], 8);
    chk("rot.g2", got[2], 0);
    chk("rot.g3", got[3], 15);
    chk("rot.g4", got[4], 8);

    @(negedge clock);
    pulse_reset();
    mode = 1'b0;
    got.delete();
    for (int c = 0; c < 10 && got.size() < 3; c++) begin
      req = 16'h8101;
      ack = m_valid;
      if (ack) got.push_back(int'(y));
      step("fxr");
    end
    req = '0;
    ack = 1'b0;
    chk("fxr.n", got.size(), 3);
    chk("fxr.g0", got[0], 15);
    chk("fxr.g1", got[1], 15);
    chk("fxr.g2", got[2], 15);

    // Set-vs-clear collision
    @(negedge clock);
    pulse_reset();
    req = 16'h0008;
    step("co1");
    req = '0;
    step("co2");
    chk("co.y3", int'(y), 3);
    req = 16'h0008;
    ack = 1'b1;
    step("co3");
    chk("co.keep", int'(pending[3]), 1);
    req = '0;
    ack = 1'b0;
    step("co4");
    chk("co.again", int'(y), 3);
    chk("co.again_v", int'(valid), 1);
    ack = 1'b1;
    step("co5");
    ack = 1'b0;

    // Grant stability
    req = 16'h0004;
    step("gs1");
    req = '0;
    step("gs2");
    req  = 16'h8000;
    mask = 16'h0004;
    for (int i = 0; i < 5; i++) begin
      step("gs");
      chk("gs.y", int'(y), 2);
      chk("gs.v", int'(valid), 1);
    end
    req = '0;
    ack = 1'b1;
    step("gs3");
    ack = 1'b0;
    step("gs4");
    chk("gs.next", int'(y), 15);
    ack  = 1'b1;
    step("gs5");
    ack  = 1'b0;
    mask = '0;

    // Asynchronous reset mid-grant
    req = 16'h0010;
    step("ar1");
    req = '0;
    step("ar2");
    chk("ar.pre", int'(valid), 1);
    #3;
    reset = 1'b1;
    #1;
    chk("ar.v", int'(valid), 0);
    chk("ar.y", int'(y), 0);
    chk("ar.p", int'(pending), 0);
    model_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("ar.idle");
      chk("ar.nogrant", int'(valid), 0);
    end
    mode = 1'b1;
    req  = 16'h8001;
    step("ar3");
    req = '0;
    step("ar4");
    chk("ar.ptr", int'(y), 15);
    ack = 1'b1;
    step("ar5");
    ack = 1'b0;

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      req = ($urandom_range(0, 3) == 0) ? N'($urandom & $urandom) : '0;
      if ($urandom_range(0, 7) == 0)
        mask = ($urandom_range(0, 1) == 0) ? '0 : N'($urandom & $urandom);
      if ($urandom_range(0, 15) == 0)
        mode = ~mode;
      ack = ($urandom_range(0, 2) != 0);
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
